// File: rtl/tour_pkg.sv
// Shared types and constants for the tour command sequencer: move encoding,
// command fields, response bytes and the sequencer state type.
package tour_pkg;

  // Bit position of each knight move in the one-hot move byte, named by compass direction
  typedef enum logic [2:0] {
    MV_NNE = 3'd0,  // (+1,+2)
    MV_NNW = 3'd1,  // (-1,+2)
    MV_WNW = 3'd2,  // (-2,+1)
    MV_WSW = 3'd3,  // (-2,-1)
    MV_SSW = 3'd4,  // (-1,-2)
    MV_SSE = 3'd5,  // (+1,-2)
    MV_ESE = 3'd6,  // (+2,-1)
    MV_ENE = 3'd7   // (+2,+1)
  } move_bit_e;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } move_delta_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [7:0] HDG_W = 8'h3F;

  localparam logic [3:0] OPC_MOVE    = 4'h2;
  localparam logic [3:0] OPC_FANFARE = 4'h3;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEG1,
    ST_WAIT1,
    ST_LEG2,
    ST_WAIT2
  } seq_state_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic move_delta_t move_delta(move_bit_e b);
    unique case (b)
      MV_NNE:  return '{dx:  3'sd1, dy:  3'sd2};
      MV_NNW:  return '{dx: -3'sd1, dy:  3'sd2};
      MV_WNW:  return '{dx: -3'sd2, dy:  3'sd1};
      MV_WSW:  return '{dx: -3'sd2, dy: -3'sd1};
      MV_SSW:  return '{dx: -3'sd1, dy: -3'sd2};
      MV_SSE:  return '{dx:  3'sd1, dy: -3'sd2};
      MV_ESE:  return '{dx:  3'sd2, dy: -3'sd1};
      MV_ENE:  return '{dx:  3'sd2, dy:  3'sd1};
      default: return '{dx:  3'sd0, dy:  3'sd0};
    endcase
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command bus between the sequencer, the UART/BLE wrapper and cmd_proc.
// master = sequencer side, slave = the surrounding wrapper and cmd_proc.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into a vertical leg command and a
// horizontal fanfare leg command; legal is low unless exactly one bit is set.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] leg1,
  output logic [15:0] leg2,
  output logic        legal
);

  move_delta_t delta;

  function automatic logic [3:0] mag(logic signed [2:0] v);
    return v[2] ? 4'(-v) : 4'(v);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    delta = '0;
    legal = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (move == (8'd1 << b)) begin
        legal = 1'b1;
        delta = move_delta(move_bit_e'(b));
      end
    end
  end

  // Sign bit of the delta picks the heading; legal moves never have a zero component
  assign leg1 = {OPC_MOVE,    delta.dy[2] ? HDG_S : HDG_N, mag(delta.dy)};
  assign leg2 = {OPC_FANFARE, delta.dx[2] ? HDG_W : HDG_E, mag(delta.dx)};

endmodule

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: walks a solved knight's tour, issues two leg commands per move
// and muxes them against UART commands toward cmd_proc. Optional macro: TOUR_ABORT_EN.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter  int NUM_MOVES = 24,
  localparam int IDX_W     = idx_width(NUM_MOVES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  tour_cmd_seq_if.master   bus,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  seq_state_t  state;
  logic [15:0] leg1_q, leg2_q;
  logic        legs_vld;
  logic [15:0] leg1, leg2;
  logic        legal;
  logic        last_move;
  logic        abort;

  tour_move_decode u_decode (
    .move  (move),
    .leg1  (leg1),
    .leg2  (leg2),
    .legal (legal)
  );

  assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));
  assign tour_busy = (state != ST_IDLE);

`ifdef TOUR_ABORT_EN
  assign abort = bus.cmd_rdy_UART;
`else
  assign abort = 1'b0;
`endif

  // LEG1 spends its first cycle checking and latching the move; legs_vld marks the latch done
  // NOTE: all state updates are non-blocking so each register sees only pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mv_indx   <= '0;
      leg1_q    <= '0;
      leg2_q    <= '0;
      legs_vld  <= 1'b0;
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
    end else begin
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          legs_vld <= 1'b0;
          if (start_tour) begin
            state   <= ST_LEG1;
            mv_indx <= '0;
          end
        end
        ST_LEG1: begin
          if (abort || (!legs_vld && !legal)) begin
            state    <= ST_IDLE;
            mv_indx  <= '0;
            tour_err <= 1'b1;
          end else if (!legs_vld) begin
            leg1_q   <= leg1;
            leg2_q   <= leg2;
            legs_vld <= 1'b1;
          end else if (bus.clr_cmd_rdy) begin
            state <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          if (bus.send_resp) state <= ST_LEG2;
        end
        ST_LEG2: begin
          if (abort) begin
            state    <= ST_IDLE;
            mv_indx  <= '0;
            tour_err <= 1'b1;
          end else if (bus.clr_cmd_rdy) begin
            state <= ST_WAIT2;
          end
        end
        ST_WAIT2: begin
          if (bus.send_resp) begin
            legs_vld <= 1'b0;
            if (last_move) begin
              state     <= ST_IDLE;
              mv_indx   <= '0;
              tour_done <= 1'b1;
            end else begin
              state   <= ST_LEG1;
              mv_indx <= mv_indx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // IDLE hands the bus to the UART path; a tour owns it otherwise
  always_comb begin
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp             = RESP_DONE;
    unique case (state)
      ST_IDLE: ;
      ST_LEG1: begin
        bus.cmd              = leg1_q;
        bus.cmd_rdy          = legs_vld;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_BUSY;
      end
      ST_WAIT1: begin
        bus.cmd              = leg1_q;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_BUSY;
      end
      ST_LEG2: begin
        bus.cmd              = leg2_q;
        bus.cmd_rdy          = 1'b1;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_BUSY;
      end
      ST_WAIT2: begin
        bus.cmd              = leg2_q;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = last_move ? RESP_DONE : RESP_BUSY;
      end
      default: ;
    endcase
  end

endmodule
